// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Time-shares one external combinational ALU among NUM_REQ requesters.
// A winner is picked per cycle, its op/operands are registered onto the ALU
// inputs, the ALU result and flags are captured one cycle later and returned
// on a valid/ready response channel tagged with the requester id.
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest valid index wins
//                          undefined -> round-robin starting after the last
//                                       granted requester (default)
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*5-1:0]    req_ctrl_i,
  input  logic [NUM_REQ*XLEN-1:0] req_a_i,
  input  logic [NUM_REQ*XLEN-1:0] req_b_i,
  output logic [4:0]              alu_ctrl_o,
  output logic [XLEN-1:0]         alu_a_o,
  output logic [XLEN-1:0]         alu_b_o,
  input  logic [XLEN-1:0]         alu_result_i,
  input  logic [2:0]              alu_flags_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [XLEN-1:0]         rsp_result_o,
  output logic [2:0]              rsp_flags_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        alu_ctrl_q, alu_ctrl_d;
  logic [XLEN-1:0]   alu_a_q, alu_a_d;
  logic [XLEN-1:0]   alu_b_q, alu_b_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [XLEN-1:0]   rsp_result_q, rsp_result_d;
  logic [2:0]        rsp_flags_q, rsp_flags_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               accept_window;
  logic               accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest valid index is assigned last.
  always_comb begin
    grant_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) grant_id = ID_W'(i);
    end
    grant           = '0;
    grant[grant_id] = |req_valid_i;
  end
`else
  logic [ID_W-1:0] rr_q, rr_d;

  // Round-robin: scan from farthest to nearest after rr_q so the nearest wins.
  always_comb begin
    grant_id = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid_i[(int'(rr_q) + k) % NUM_REQ]) grant_id = ID_W'((int'(rr_q) + k) % NUM_REQ);
    end
    grant           = '0;
    grant[grant_id] = |req_valid_i;
  end

  // The pointer moves to the winner only when a request is actually taken.
  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = grant_id;
  end

  // Pointer register; reset to the last index so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= ID_W'(NUM_REQ - 1);
    else         rr_q <= rr_d;
  end
`endif

  // A new request can be taken when idle, or when the pending response leaves this cycle.
  always_comb begin
    accept_window = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
    req_ready_o   = accept_window ? grant : '0;
    accept        = accept_window && (|req_valid_i);
  end

  // Next-state, operand latching and response capture.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;

    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_result_d = alu_result_i;
        rsp_flags_d  = alu_flags_i;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = accept ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      alu_ctrl_d = req_ctrl_i[grant_id*5 +: 5];
      alu_a_d    = req_a_i[grant_id*XLEN +: XLEN];
      alu_b_d    = req_b_i[grant_id*XLEN +: XLEN];
      id_d       = grant_id;
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      state_q      <= IDLE;
      alu_ctrl_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign alu_ctrl_o   = alu_ctrl_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_flags_o  = rsp_flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Randomized + directed bench. A behavioural ALU answers the DUT's ALU port.
// The monitor keeps a transaction-level model (who should win, whether a
// response is owed and when) and a scoreboard of expected responses pushed
// at each accepted request.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;
  localparam int ID_W    = $clog2(NUM_REQ);

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic [NUM_REQ-1:0]      req_valid_i;
  logic [NUM_REQ-1:0]      req_ready_o;
  logic [NUM_REQ*5-1:0]    req_ctrl_i;
  logic [NUM_REQ*XLEN-1:0] req_a_i;
  logic [NUM_REQ*XLEN-1:0] req_b_i;
  logic [4:0]              alu_ctrl_o;
  logic [XLEN-1:0]         alu_a_o;
  logic [XLEN-1:0]         alu_b_o;
  logic [XLEN-1:0]         alu_result_i;
  logic [2:0]              alu_flags_i;
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [ID_W-1:0]         rsp_id_o;
  logic [XLEN-1:0]         rsp_result_o;
  logic [2:0]              rsp_flags_o;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .ID_W(ID_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_ctrl_i   (req_ctrl_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_result_i (alu_result_i),
    .alu_flags_i  (alu_flags_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_result_o (rsp_result_o),
    .rsp_flags_o  (rsp_flags_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural shared ALU: returns {result, zero, ge_signed, ge_unsigned}.
  function automatic logic [XLEN+2:0] alu_fn(input logic [4:0] op, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op)
      5'd0:    r = a + b;
      5'd1:    r = a - b;
      5'd2:    r = a & b;
      5'd3:    r = a | b;
      5'd4:    r = a ^ b;
      5'd5:    r = XLEN'($signed(a) < $signed(b));
      5'd6:    r = XLEN'(a < b);
      5'd7:    r = a << b[4:0];
      5'd8:    r = $signed(a) >>> b[4:0];
      5'd9:    r = a >> b[4:0];
      5'd10:   r = a;
      5'd11:   r = b;
      5'd12:   r = ~(a | b);
      default: r = a + b;
    endcase
    return {r, (r == '0), ($signed(a) >= $signed(b)), (a >= b)};
  endfunction

  always_comb {alu_result_i, alu_flags_i} = alu_fn(alu_ctrl_o, alu_a_o, alu_b_o);

  // Which requester the arbitration rule selects, or -1 if none is valid.
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NUM_REQ; k++) if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
`endif
    return -1;
  endfunction

  typedef struct {
    int              id;
    logic [XLEN-1:0] res;
    logic [2:0]      flags;
  } exp_t;

  exp_t             sb_q[$];
  int               grant_log[$];
  int               last_gnt = NUM_REQ - 1;
  bit               inflight = 1'b0;
  int               age = 0;
  int               rsp_cnt = 0;
  bit               hold_prev = 1'b0;
  logic [ID_W-1:0]  hold_id;
  logic [XLEN-1:0]  hold_res;
  logic [2:0]       hold_flags;
  int               last_id;
  logic [XLEN-1:0]  last_res;
  logic [2:0]       last_flags;

  // Monitor: samples on the falling edge, between the driver's updates and the next active edge.
  always @(negedge clk_i) begin
    int                 win, idx;
    bit                 exp_v, window;
    logic [NUM_REQ-1:0] exp_rdy, acc;
    logic [XLEN+2:0]    m;
    exp_t               e;
    if (!rst_ni) begin
      last_gnt  = NUM_REQ - 1;
      inflight  = 1'b0;
      age       = 0;
      hold_prev = 1'b0;
      sb_q.delete();
      grant_log.delete();
    end else begin
      if (inflight) age++;
      exp_v = inflight && (age >= 2);
      check("rsp_valid", 64'(rsp_valid_o), 64'(exp_v));
      if (hold_prev) begin
        check("hold_id", 64'(rsp_id_o), 64'(hold_id));
        check("hold_result", 64'(rsp_result_o), 64'(hold_res));
        check("hold_flags", 64'(rsp_flags_o), 64'(hold_flags));
      end
      win     = pick(req_valid_i, last_gnt);
      window  = !inflight || (exp_v && rsp_ready_i);
      exp_rdy = (window && win >= 0) ? (NUM_REQ'(1) << win) : '0;
      check("req_ready", 64'(req_ready_o), 64'(exp_rdy));

      hold_prev  = rsp_valid_o && !rsp_ready_i;
      hold_id    = rsp_id_o;
      hold_res   = rsp_result_o;
      hold_flags = rsp_flags_o;

      if (rsp_valid_o && rsp_ready_i) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid_o), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check("rsp_id", 64'(rsp_id_o), 64'(e.id));
          check("rsp_result", 64'(rsp_result_o), 64'(e.res));
          check("rsp_flags", 64'(rsp_flags_o), 64'(e.flags));
          last_id    = int'(rsp_id_o);
          last_res   = rsp_result_o;
          last_flags = rsp_flags_o;
          rsp_cnt++;
        end
        inflight = 1'b0;
      end

      acc = req_valid_i & req_ready_o;
      if (acc != '0) begin
        idx = 0;
        for (int i = 0; i < NUM_REQ; i++) if (acc[i]) idx = i;
        m = alu_fn(req_ctrl_i[idx*5 +: 5], req_a_i[idx*XLEN +: XLEN], req_b_i[idx*XLEN +: XLEN]);
        e.id    = idx;
        e.res   = m[XLEN+2:3];
        e.flags = m[2:0];
        sb_q.push_back(e);
        grant_log.push_back(idx);
        last_gnt = idx;
        inflight = 1'b1;
        age      = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input int i, input logic [4:0] c, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b);
    req_valid_i[i]           = 1'b1;
    req_ctrl_i[i*5 +: 5]     = c;
    req_a_i[i*XLEN +: XLEN]  = a;
    req_b_i[i*XLEN +: XLEN]  = b;
  endtask

  task automatic new_op(input int i);
    logic [XLEN-1:0] a, b;
    a = ($urandom_range(3) == 0) ? XLEN'($urandom_range(15)) : XLEN'($urandom);
    b = ($urandom_range(3) == 0) ? a : XLEN'($urandom);
    set_op(i, 5'($urandom_range(15)), a, b);
  endtask

  // Per-cycle requester/consumer behaviour: hold until accepted, optionally drop early.
  task automatic drive_cycles(input int n, input int pval, input bit allow_drop, input int prdy);
    logic [NUM_REQ-1:0] acc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      acc = req_valid_i & req_ready_o;
      @(posedge clk_i);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i] || !req_valid_i[i]) begin
          if (int'($urandom_range(99)) < pval) new_op(i);
          else req_valid_i[i] = 1'b0;
        end else if (allow_drop && $urandom_range(99) < 5) begin
          req_valid_i[i] = 1'b0;
        end
      end
      rsp_ready_i = int'($urandom_range(99)) < prdy;
    end
  endtask

  task automatic idle_drain(input int n);
    @(posedge clk_i);
    #1;
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    repeat (n) @(posedge clk_i);
  endtask

  task automatic wait_ready(input int i, output int waited);
    for (waited = 0; waited < 20; waited++) begin
      @(negedge clk_i);
      if (req_ready_o[i]) break;
    end
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'(0));
    check({tag, "_rsp_id"}, 64'(rsp_id_o), 64'(0));
    check({tag, "_rsp_result"}, 64'(rsp_result_o), 64'(0));
    check({tag, "_rsp_flags"}, 64'(rsp_flags_o), 64'(0));
    check({tag, "_alu_ctrl"}, 64'(alu_ctrl_o), 64'(0));
    check({tag, "_alu_a"}, 64'(alu_a_o), 64'(0));
    check({tag, "_alu_b"}, 64'(alu_b_o), 64'(0));
    check({tag, "_req_ready"}, 64'(req_ready_o), 64'(0));
  endtask

  // Directed op from an idle DUT, checked against hand-computed constants.
  task automatic issue(input int i, input logic [4:0] c, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                       input logic [2:0] exp_flags);
    int waited, c0, w2;
    @(posedge clk_i);
    #1;
    set_op(i, c, a, b);
    rsp_ready_i = 1'b1;
    wait_ready(i, waited);
    check("issue_ready_same_cycle", 64'(waited), 64'(0));
    c0 = rsp_cnt;
    @(posedge clk_i);
    #1;
    req_valid_i[i] = 1'b0;
    for (w2 = 0; w2 < 20; w2++) begin
      @(negedge clk_i);
      #1;
      if (rsp_cnt != c0) break;
    end
    check("issue_rsp_seen", 64'(rsp_cnt != c0), 64'(1));
    check("issue_id", 64'(last_id), 64'(i));
    check("issue_result", 64'(last_res), 64'(exp_res));
    check("issue_flags", 64'(last_flags), 64'(exp_flags));
  endtask

  task automatic check_order(input string tag, input int first_two_only);
    int n;
    n = first_two_only ? 2 : 4;
    check({tag, "_count"}, 64'(grant_log.size() >= n), 64'(1));
    for (int k = 0; k < n; k++) begin
      if (k < grant_log.size()) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        check({tag, "_grant"}, 64'(grant_log[k]), 64'(0));
`else
        check({tag, "_grant"}, 64'(grant_log[k]), 64'(k % 2));
`endif
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1);
  end

  initial begin
    int waited;
    rst_ni      = 1'b1;
    req_valid_i = '0;
    req_ctrl_i  = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1 reset_outputs_zero("reset");
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Both requesters always valid, consumer always ready.
    grant_log.delete();
    drive_cycles(10, 100, 1'b0, 100);
    check_order("contention", 0);
    idle_drain(4);

    // Directed ALU cases from an idle arbiter.
    issue(0, 5'd0, 32'd5, 32'd7, 32'd12, 3'b000);
    issue(1, 5'd1, 32'd3, 32'd3, 32'd0, 3'b111);
    issue(1, 5'd8, 32'h8000_0000, 32'd4, 32'hF800_0000, 3'b001);
    idle_drain(2);

    // Response back-pressure, with requester 1 pending behind it.
    @(posedge clk_i);
    #1;
    set_op(0, 5'd4, 32'hA5A5_0000, 32'h0000_5A5A);
    rsp_ready_i = 1'b0;
    wait_ready(0, waited);
    check("stall_first_accept", 64'(waited), 64'(0));
    @(posedge clk_i);
    #1;
    req_valid_i[0] = 1'b0;
    set_op(1, 5'd2, 32'hFFFF_00FF, 32'h0F0F_0F0F);
    for (waited = 0; waited < 20; waited++) begin
      @(negedge clk_i);
      if (rsp_valid_o) break;
    end
    check("stall_rsp_seen", 64'(rsp_valid_o), 64'(1));
    repeat (5) @(posedge clk_i);
    #1 rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("stall_release_accept", 64'(req_ready_o), 64'(2'b10));
    @(posedge clk_i);
    #1 req_valid_i[1] = 1'b0;
    idle_drain(4);

    // Randomized traffic with early drops and random back-pressure.
    drive_cycles(600, 60, 1'b1, 70);
    idle_drain(5);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    // Reset while an op is in EXEC: it must vanish without a response.
    @(posedge clk_i);
    #1;
    set_op(0, 5'd0, 32'd100, 32'd200);
    rsp_ready_i = 1'b1;
    wait_ready(0, waited);
    check("rst_exec_accept", 64'(waited), 64'(0));
    @(posedge clk_i);
    #2;
    req_valid_i = '0;
    rst_ni      = 1'b0;
    #1 reset_outputs_zero("rst_exec");
    repeat (2) @(posedge clk_i);
    #1;
    new_op(0);
    new_op(1);
    #2 rst_ni = 1'b1;
    drive_cycles(8, 100, 1'b0, 100);
    check_order("post_reset", 1);
    idle_drain(5);
    check("final_scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
